// File: rtl/leaf_vote_accumulator_pkg.sv
// Forest-wide shared definitions: default sizing, branch-stage node layout and
// the leaf vote accumulator state encoding.
package leaf_vote_accumulator_pkg;

  localparam int unsigned DEF_NUM_TREES   = 3;
  localparam int unsigned DEF_IDX_W       = 4;
  localparam int unsigned DEF_NUM_CLASSES = 4;

  localparam int unsigned FEAT_W   = 4;
  localparam int unsigned THRESH_W = 8;

  typedef struct packed {
    logic [FEAT_W-1:0]   feature;
    logic [THRESH_W-1:0] threshold;
    logic                is_leaf;
  } branch_node_t;

  typedef enum logic [1:0] {
    COLLECT,
    COUNT,
    ARGMAX,
    OUT
  } vote_state_t;

  // Select width that never collapses to zero for single-entry ranges.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/leaf_vote_accumulator_leaf_table.sv
// Per-tree leaf-to-class lookup: one write port, one combinational read port,
// synchronous clear to class 0.
module leaf_table
  import leaf_vote_accumulator_pkg::*;
#(
  parameter int unsigned NUM_TREES = DEF_NUM_TREES,
  parameter int unsigned IDX_W     = DEF_IDX_W,
  parameter int unsigned CLASS_W   = 2,
  parameter int unsigned TREE_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [TREE_W-1:0]  wr_tree,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [CLASS_W-1:0] wr_class,
  input  logic [TREE_W-1:0]  rd_tree,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CLASS_W-1:0] rd_class
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [CLASS_W-1:0] mem [NUM_TREES][DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < NUM_TREES; t++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[TREE_W'(t)][IDX_W'(i)] <= '0;
        end
      end
    end else if (we && (32'(wr_tree) < NUM_TREES)) begin
      mem[wr_tree][wr_idx] <= wr_class;
    end
  end

  // Read is combinational, so a same-cycle write is seen only after the edge.
  assign rd_class = mem[rd_tree][rd_idx];

endmodule

// File: rtl/leaf_vote_accumulator.sv
// Collects one leaf index per tree, counts class votes one tree per cycle,
// picks the winning class (lowest on ties) and holds it until accepted.
module leaf_vote_accumulator
  import leaf_vote_accumulator_pkg::*;
#(
  parameter  int unsigned NUM_TREES   = DEF_NUM_TREES,
  parameter  int unsigned IDX_W       = DEF_IDX_W,
  parameter  int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  localparam int unsigned CLASS_W     = width_of(NUM_CLASSES),
  localparam int unsigned TREE_W      = width_of(NUM_TREES),
  localparam int unsigned VOTE_W      = $clog2(NUM_TREES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_TREES*IDX_W-1:0] nodeIdxIn,
  input  logic [NUM_TREES-1:0]       nodeValIn,
  output logic [NUM_TREES-1:0]       recOut,
  input  logic                       tblWe,
  input  logic [TREE_W-1:0]          tblTree,
  input  logic [IDX_W-1:0]           tblIdx,
  input  logic [CLASS_W-1:0]         tblClass,
  output logic [CLASS_W-1:0]         classOut,
  output logic [VOTE_W-1:0]          voteOut,
  output logic                       outVal,
  input  logic                       outRec
);

  vote_state_t state, state_next;

  logic [NUM_TREES-1:0] held;
  logic [IDX_W-1:0]     hold_idx [NUM_TREES];
  logic [VOTE_W-1:0]    votes    [NUM_CLASSES];
  logic [TREE_W-1:0]    ptr;
  logic [CLASS_W-1:0]   cptr;
  logic [CLASS_W-1:0]   best;
  logic [VOTE_W-1:0]    best_votes;
  logic [CLASS_W-1:0]   leaf_class;
  logic                 all_held;
  logic                 last_tree;
  logic                 last_class;

  assign all_held   = &held;
  assign last_tree  = (ptr == TREE_W'(NUM_TREES - 1));
  assign last_class = (cptr == CLASS_W'(NUM_CLASSES - 1));

  leaf_table #(
    .NUM_TREES (NUM_TREES),
    .IDX_W     (IDX_W),
    .CLASS_W   (CLASS_W),
    .TREE_W    (TREE_W)
  ) u_leaf_table (
    .clk      (clk),
    .rst      (rst),
    .we       (tblWe),
    .wr_tree  (tblTree),
    .wr_idx   (tblIdx),
    .wr_class (tblClass),
    .rd_tree  (ptr),
    .rd_idx   (hold_idx[ptr]),
    .rd_class (leaf_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    recOut     = '0;
    outVal     = 1'b0;
    case (state)
      COLLECT: begin
        recOut = ~held;
        if (all_held) state_next = COUNT;
      end
      COUNT:  if (last_tree) state_next = ARGMAX;
      ARGMAX: if (last_class) state_next = OUT;
      OUT: begin
        outVal = 1'b1;
        if (outRec) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= '0;
      ptr        <= '0;
      cptr       <= '0;
      best       <= '0;
      best_votes <= '0;
      for (int unsigned t = 0; t < NUM_TREES; t++) hold_idx[TREE_W'(t)] <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) votes[CLASS_W'(c)] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          for (int unsigned t = 0; t < NUM_TREES; t++) begin
            if (nodeValIn[TREE_W'(t)] && recOut[TREE_W'(t)]) begin
              held[TREE_W'(t)]     <= 1'b1;
              hold_idx[TREE_W'(t)] <= nodeIdxIn[t*IDX_W +: IDX_W];
            end
          end
          if (all_held) begin
            ptr <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) votes[CLASS_W'(c)] <= '0;
          end
        end
        COUNT: begin
          votes[leaf_class] <= votes[leaf_class] + VOTE_W'(1);
          ptr               <= ptr + TREE_W'(1);
          if (last_tree) begin
            cptr       <= '0;
            best       <= '0;
            best_votes <= '0;
          end
        end
        ARGMAX: begin
          // Strict compare keeps the earliest (lowest) class on a tie.
          if (votes[cptr] > best_votes) begin
            best       <= cptr;
            best_votes <= votes[cptr];
          end
          cptr <= cptr + CLASS_W'(1);
        end
        OUT: begin
          if (outRec) held <= '0;
        end
        default: ;
      endcase
    end
  end

  assign classOut = best;
  assign voteOut  = best_votes;

endmodule
